// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle. The pipeline is the master and the
// controller is the slave.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic             MemRead_E, PCSrc_E, RegWrite_M, RegWrite_W;
  logic             dmem_req_M, dmem_ready, cnt_clr;
  logic             stall_F, stall_D, stall_E, stall_M;
  logic             flush_D, flush_E, flush_W;
  logic [1:0]       fwdA_E, fwdB_E;
  logic             err;
  logic [CNT_W-1:0] cnt_stall, cnt_flush;

  modport master (
    output rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
           MemRead_E, PCSrc_E, RegWrite_M, RegWrite_W,
           dmem_req_M, dmem_ready, cnt_clr,
    input  stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W,
           fwdA_E, fwdB_E, err, cnt_stall, cnt_flush
  );

  modport slave (
    input  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
           MemRead_E, PCSrc_E, RegWrite_M, RegWrite_W,
           dmem_req_M, dmem_ready, cnt_clr,
    output stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W,
           fwdA_E, fwdB_E, err, cnt_stall, cnt_flush
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipeline: forwarding selects,
// load-use stall, branch flush, memory-wait freeze with watchdog, perf counters.

// E-stage forwarding select for one source operand; M result beats W result.
module hz_fwd_sel (
  input  logic [4:0] rs,
  input  logic [4:0] rd_m,
  input  logic       we_m,
  input  logic [4:0] rd_w,
  input  logic       we_w,
  output logic [1:0] sel
);
  always_comb begin
    sel = 2'b00;
    if (we_m && (rd_m != 5'd0) && (rd_m == rs))      sel = 2'b10;
    else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) sel = 2'b01;
  end
endmodule

// Saturating event counter; clr takes priority over inc.
module hz_sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= '0;
    else if (clr)            cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
  end
endmodule

module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  pipe_hazard_ctrl_if.slave  hz
);
  localparam int NUM_SRC = 2;

  typedef enum logic [1:0] {RUN, MEMWAIT, ERROR} state_t;

  state_t                          state, state_nxt;
  logic [TO_W-1:0]                 wait_cnt, wait_nxt;
  logic                            err_q, err_nxt;
  logic                            mem_stall, lu_hit;
  logic                            stall_all, flush_br, lu_stall;
  logic [NUM_SRC-1:0][4:0]         rs_e;
  logic [NUM_SRC-1:0][1:0]         sel;

  // Forwarding is purely combinational and independent of FSM state.
  assign rs_e = {hz.rs2_E, hz.rs1_E};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
    hz_fwd_sel u_sel (
      .rs   (rs_e[g]),
      .rd_m (hz.rd_M),
      .we_m (hz.RegWrite_M),
      .rd_w (hz.rd_W),
      .we_w (hz.RegWrite_W),
      .sel  (sel[g])
    );
  end

  assign mem_stall = hz.dmem_req_M & ~hz.dmem_ready;
  // rs2_D is compared for every format; a false stall costs one cycle, a miss is a bug.
  assign lu_hit    = hz.MemRead_E & (hz.rd_E != 5'd0) &
                     ((hz.rd_E == hz.rs1_D) | (hz.rd_E == hz.rs2_D));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      err_q    <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    err_nxt   = err_q;
    stall_all = 1'b0;
    flush_br  = 1'b0;
    lu_stall  = 1'b0;
    case (state)
      RUN: begin
        if (mem_stall) begin
          state_nxt = MEMWAIT;
          wait_nxt  = TO_W'(1);
          stall_all = 1'b1;
        end else begin
          flush_br = hz.PCSrc_E;
          lu_stall = lu_hit & ~hz.PCSrc_E;
        end
      end
      MEMWAIT: begin
        if (mem_stall) begin
          stall_all = 1'b1;
          if (wait_cnt == TO_W'(TIMEOUT)) begin
            state_nxt = ERROR;
            err_nxt   = 1'b1;
          end else begin
            wait_nxt = wait_cnt + 1'b1;
          end
        end else begin
          // E was frozen during the wait, so a held PCSrc_E flushes here.
          state_nxt = RUN;
          wait_nxt  = '0;
          flush_br  = hz.PCSrc_E;
          lu_stall  = lu_hit & ~hz.PCSrc_E;
        end
      end
      ERROR:   stall_all = 1'b1;
      default: state_nxt = RUN;
    endcase
  end

  // Every output is held low while reset is asserted.
  assign hz.stall_F = rst_n & (stall_all | lu_stall);
  assign hz.stall_D = rst_n & (stall_all | lu_stall);
  assign hz.stall_E = rst_n & stall_all;
  assign hz.stall_M = rst_n & stall_all;
  assign hz.flush_W = rst_n & stall_all;
  assign hz.flush_D = rst_n & flush_br;
  assign hz.flush_E = rst_n & (flush_br | lu_stall);
  assign hz.fwdA_E  = rst_n ? sel[0] : 2'b00;
  assign hz.fwdB_E  = rst_n ? sel[1] : 2'b00;
  assign hz.err     = err_q;

  hz_sat_cnt #(.W(CNT_W)) u_cnt_stall (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (hz.cnt_clr),
    .inc   (hz.stall_F),
    .cnt   (hz.cnt_stall)
  );

  hz_sat_cnt #(.W(CNT_W)) u_cnt_flush (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (hz.cnt_clr),
    .inc   (hz.flush_D),
    .cnt   (hz.cnt_flush)
  );
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl (TIMEOUT=4, CNT_W=4): vector table plus hand sequences,
// expectations queued at drive time and checked on the falling edge.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(4)) hz ();

  pipe_hazard_ctrl #(.TIMEOUT(4), .TO_W(8), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz.slave)
  );

  typedef struct packed {
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
    logic       mem_read_e, pc_src_e;
    logic [4:0] rd_m;
    logic       reg_write_m;
    logic [4:0] rd_w;
    logic       reg_write_w;
    logic       dmem_req_m, dmem_ready, cnt_clr;
  } in_t;

  typedef struct packed {
    logic       stall_f, stall_d, stall_e, stall_m;
    logic       flush_d, flush_e, flush_w;
    logic [1:0] fwd_a, fwd_b;
    logic       err;
  } ctl_t;

  typedef struct {
    string nm;
    in_t   i;
    ctl_t  e;
  } vec_t;

  typedef struct {
    string      nm;
    ctl_t       e;
    bit         chk;
    logic [3:0] cs, cf;
  } exp_t;

  exp_t q[$];
  int   nvec = 0;
  int   nerr = 0;

  ctl_t c_idle, c_lu, c_br, c_mem, c_err;
  in_t  i_idle, i_lu, i_br, i_mw;

  task automatic drive(input in_t i);
    hz.rs1_D      = i.rs1_d;
    hz.rs2_D      = i.rs2_d;
    hz.rs1_E      = i.rs1_e;
    hz.rs2_E      = i.rs2_e;
    hz.rd_E       = i.rd_e;
    hz.MemRead_E  = i.mem_read_e;
    hz.PCSrc_E    = i.pc_src_e;
    hz.rd_M       = i.rd_m;
    hz.RegWrite_M = i.reg_write_m;
    hz.rd_W       = i.rd_w;
    hz.RegWrite_W = i.reg_write_w;
    hz.dmem_req_M = i.dmem_req_m;
    hz.dmem_ready = i.dmem_ready;
    hz.cnt_clr    = i.cnt_clr;
  endtask

  // One cycle: apply after the rising edge, queue what the falling edge must show.
  task automatic step(input string nm, input logic rn, input in_t i, input ctl_t e,
                      input bit chk, input int cs, input int cf);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n = rn;
    drive(i);
    x.nm  = nm;
    x.e   = e;
    x.chk = chk;
    x.cs  = 4'(cs);
    x.cf  = 4'(cf);
    q.push_back(x);
  endtask

  always @(negedge clk) begin
    exp_t x;
    ctl_t a;
    if (q.size() > 0) begin
      x = q.pop_front();
      a = {hz.stall_F, hz.stall_D, hz.stall_E, hz.stall_M, hz.flush_D, hz.flush_E,
           hz.flush_W, hz.fwdA_E, hz.fwdB_E, hz.err};
      nvec++;
      if (a !== x.e || (x.chk && (hz.cnt_stall !== x.cs || hz.cnt_flush !== x.cf))) begin
        nerr++;
        $display("FAIL %s: got ctl=%b cnt_stall=%0d cnt_flush=%0d, want ctl=%b cnt_stall=%0d cnt_flush=%0d%s",
                 x.nm, a, hz.cnt_stall, hz.cnt_flush, x.e, x.cs, x.cf,
                 x.chk ? "" : " (counters not checked)");
      end
    end
  end

  vec_t tbl[13];

  initial begin
    c_idle = '0;
    c_lu   = '{default: '0, stall_f: 1'b1, stall_d: 1'b1, flush_e: 1'b1};
    c_br   = '{default: '0, flush_d: 1'b1, flush_e: 1'b1};
    c_mem  = '{default: '0, stall_f: 1'b1, stall_d: 1'b1, stall_e: 1'b1, stall_m: 1'b1,
               flush_w: 1'b1};
    c_err  = c_mem;
    c_err.err = 1'b1;

    i_idle = '0;
    i_lu   = '{default: '0, mem_read_e: 1'b1, rd_e: 5'd7, rs2_d: 5'd7};
    i_br   = '{default: '0, pc_src_e: 1'b1};
    i_mw   = '{default: '0, dmem_req_m: 1'b1};

    tbl[0]  = '{"fwd_m_beats_w", '{default: '0, rs1_e: 5'd5, rd_m: 5'd5, reg_write_m: 1'b1,
               rd_w: 5'd5, reg_write_w: 1'b1}, '{default: '0, fwd_a: 2'b10}};
    tbl[1]  = '{"fwd_rdm_zero", '{default: '0, rs1_e: 5'd5, rd_m: 5'd0, reg_write_m: 1'b1,
               rd_w: 5'd5, reg_write_w: 1'b1}, '{default: '0, fwd_a: 2'b01}};
    tbl[2]  = '{"fwd_none", '{default: '0, rs1_e: 5'd5, rd_m: 5'd3, reg_write_m: 1'b1,
               rd_w: 5'd0, reg_write_w: 1'b1}, '{default: '0}};
    tbl[3]  = '{"fwd_b_w_only", '{default: '0, rs2_e: 5'd9, rd_m: 5'd9, reg_write_m: 1'b0,
               rd_w: 5'd9, reg_write_w: 1'b1}, '{default: '0, fwd_b: 2'b01}};
    tbl[4]  = '{"fwd_a_w_b_m", '{default: '0, rs1_e: 5'd4, rs2_e: 5'd6, rd_m: 5'd6,
               reg_write_m: 1'b1, rd_w: 5'd4, reg_write_w: 1'b1},
               '{default: '0, fwd_a: 2'b01, fwd_b: 2'b10}};
    tbl[5]  = '{"lu_rs2", i_lu, c_lu};
    tbl[6]  = '{"lu_rd_zero", '{default: '0, mem_read_e: 1'b1, rd_e: 5'd0}, c_idle};
    tbl[7]  = '{"lu_rs1", '{default: '0, mem_read_e: 1'b1, rd_e: 5'd3, rs1_d: 5'd3}, c_lu};
    tbl[8]  = '{"no_load", '{default: '0, mem_read_e: 1'b0, rd_e: 5'd3, rs1_d: 5'd3}, c_idle};
    tbl[9]  = '{"branch", i_br, c_br};
    tbl[10] = '{"branch_beats_lu", '{default: '0, pc_src_e: 1'b1, mem_read_e: 1'b1,
               rd_e: 5'd7, rs2_d: 5'd7}, c_br};
    tbl[11] = '{"memstall_beats_all", '{default: '0, dmem_req_m: 1'b1, pc_src_e: 1'b1,
               mem_read_e: 1'b1, rd_e: 5'd7, rs2_d: 5'd7}, c_mem};
    tbl[12] = '{"mem_ready", '{default: '0, dmem_req_m: 1'b1, dmem_ready: 1'b1}, c_idle};

    drive(i_idle);

    // Outputs held low during reset even with hazard-triggering inputs.
    step("reset_outputs", 1'b0, '{default: '0, rs1_e: 5'd5, rd_m: 5'd5, reg_write_m: 1'b1,
         dmem_req_m: 1'b1, pc_src_e: 1'b1}, c_idle, 1'b1, 0, 0);
    step("reset_release", 1'b1, i_idle, c_idle, 1'b1, 0, 0);

    for (int k = 0; k < 13; k++) step(tbl[k].nm, 1'b1, tbl[k].i, tbl[k].e, 1'b0, 0, 0);

    // Table produced stalls in 3 cycles and branch flushes in 2.
    step("clr_reads_old", 1'b1, '{default: '0, cnt_clr: 1'b1}, c_idle, 1'b1, 3, 2);
    step("clr_zero", 1'b1, i_idle, c_idle, 1'b1, 0, 0);

    step("br_pulse", 1'b1, i_br, c_br, 1'b1, 0, 0);
    step("br_counted", 1'b1, i_idle, c_idle, 1'b1, 0, 1);

    step("mw1", 1'b1, i_mw, c_mem, 1'b1, 0, 1);
    step("mw2", 1'b1, i_mw, c_mem, 1'b1, 1, 1);
    step("mw3", 1'b1, i_mw, c_mem, 1'b1, 2, 1);
    step("mw_ready", 1'b1, '{default: '0, dmem_req_m: 1'b1, dmem_ready: 1'b1}, c_idle, 1'b1, 3, 1);
    step("mw_after", 1'b1, i_idle, c_idle, 1'b1, 3, 1);

    // Branch resolved while memory stalls: flush lands when the stall drops.
    step("dbr_wait", 1'b1, '{default: '0, dmem_req_m: 1'b1, pc_src_e: 1'b1}, c_mem, 1'b1, 3, 1);
    step("dbr_flush", 1'b1, '{default: '0, dmem_req_m: 1'b1, dmem_ready: 1'b1, pc_src_e: 1'b1},
         c_br, 1'b1, 4, 1);
    step("dbr_counted", 1'b1, i_idle, c_idle, 1'b1, 4, 2);

    step("sat_clr", 1'b1, '{default: '0, cnt_clr: 1'b1}, c_idle, 1'b1, 4, 2);
    for (int k = 0; k < 18; k++)
      step($sformatf("sat_%0d", k), 1'b1, i_lu, c_lu, 1'b1, (k > 15) ? 15 : k, 0);
    step("sat_hold", 1'b1, i_idle, c_idle, 1'b1, 15, 0);
    begin
      in_t lc;
      lc = i_lu;
      lc.cnt_clr = 1'b1;
      step("clr_beats_inc", 1'b1, lc, c_lu, 1'b1, 15, 0);
    end
    step("clr_beats_inc_zero", 1'b1, i_idle, c_idle, 1'b1, 0, 0);

    // Watchdog: RUN->MEMWAIT, then four MEMWAIT cycles before ERROR.
    for (int k = 1; k <= 5; k++)
      step($sformatf("to_wait_%0d", k), 1'b1, i_mw, c_mem, 1'b1, k - 1, 0);
    step("err_sticky_idle", 1'b1, i_idle, c_err, 1'b1, 5, 0);
    step("err_sticky_ready", 1'b1, '{default: '0, dmem_req_m: 1'b1, dmem_ready: 1'b1},
         c_err, 1'b1, 6, 0);
    step("err_reset", 1'b0, '{default: '0, rs1_e: 5'd5, rd_m: 5'd5, reg_write_m: 1'b1},
         c_idle, 1'b1, 0, 0);
    step("err_reset_run", 1'b1, i_idle, c_idle, 1'b1, 0, 0);
    step("post_reset_branch", 1'b1, i_br, c_br, 1'b1, 0, 0);

    for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      nerr++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "timeout");
  end
endmodule
